// File: rtl/arith_result_uart_tx_pkg.sv
// Shared types and ASCII constants for the arithmetic-result UART readout.
// Holds both FSM encodings and the nibble-to-hex helper.
package arith_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND_CHAR,
    NEXT,
    FINISH
  } state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  localparam logic [7:0] CHAR_V     = 8'h56;
  localparam logic [7:0] CHAR_DASH  = 8'h2D;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  localparam int NUM_CHARS = 4;

  function automatic logic [7:0] nibble_to_ascii(
    input logic [3:0] n
  );
    logic [7:0] c;
    if (n < 4'd10) begin
      c = ASCII_ZERO + {4'd0, n};
    end else begin
      c = ASCII_A + ({4'd0, n} - 8'd10);
    end
    return c;
  endfunction

endpackage

// File: rtl/arith_result_uart_tx_if.sv
// Request/status bundle between the arithmetic stage and the
// UART readout block.
interface arith_result_uart_tx_if;

  logic       send;
  logic [7:0] result;
  logic       overflow;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output send,
    output result,
    output overflow,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  send,
    input  result,
    input  overflow,
    output tx,
    output busy,
    output done
  );

endinterface

// File: rtl/arith_result_uart_tx_byte.sv
// 8N1 byte transmitter; done fires one cycle before the stop bit ends
// so the caller can chain the next byte with no idle gap.
module uart_tx_byte
  import arith_uart_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW =
    (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
  localparam logic [CW-1:0] LAST =
    CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] PRE =
    CW'(BAUD_DIV - 2);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (baud_q == LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        if (start) begin
          state_d = TX_START;
          shift_d = din;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      TX_STOP: begin
        // A start in the last stop cycle chains straight into the next frame
        if (bit_end) begin
          if (start) begin
            state_d = TX_START;
            shift_d = din;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    unique case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != TX_IDLE);
  assign done = (state_q == TX_STOP) &&
                (baud_q == PRE);

endmodule

// File: rtl/arith_result_uart_tx.sv
// Serial readout of the add/sub stage: sends two hex digits, an
// overflow flag character and CR as back-to-back 8N1 frames.
module arith_result_uart_tx
  import arith_uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input logic                   clk,
  input logic                   rst,
  arith_result_uart_tx_if.slave bus
);

  localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam logic [1:0] IDX_LAST = 2'(NUM_CHARS - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] res_q, res_d;
  logic       ovf_q, ovf_d;
  logic       send_q, send_d;
  logic       start_cond;

  logic       byte_start;
  logic [7:0] byte_din;
  logic       byte_tx;
  logic       byte_busy;
  logic       byte_done;

  function automatic logic [7:0] char_at(
    input logic [1:0] i,
    input logic [7:0] r,
    input logic       o
  );
    logic [7:0] c;
    case (i)
      2'd0:    c = nibble_to_ascii(r[7:4]);
      2'd1:    c = nibble_to_ascii(r[3:0]);
      2'd2:    c = o ? CHAR_V : CHAR_DASH;
      default: c = CHAR_CR;
    endcase
    return c;
  endfunction

  assign send_d = bus.send;
  assign start_cond = bus.send && !send_q &&
                      (state_q == IDLE) && !byte_busy;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    byte_start = 1'b0;
    byte_din   = char_at(idx_q, res_q, ovf_q);
    unique case (state_q)
      IDLE: begin
        // First char is built from the live inputs so tx falls next cycle
        if (start_cond) begin
          res_d      = bus.result;
          ovf_d      = bus.overflow;
          idx_d      = '0;
          byte_start = 1'b1;
          byte_din   = char_at(2'd0, bus.result,
                               bus.overflow);
          state_d    = SEND_CHAR;
        end
      end
      SEND_CHAR: begin
        if (byte_done) state_d = NEXT;
      end
      NEXT: begin
        if (idx_q != IDX_LAST) begin
          idx_d      = idx_q + 2'd1;
          byte_start = 1'b1;
          byte_din   = char_at(idx_q + 2'd1, res_q,
                               ovf_q);
          state_d    = SEND_CHAR;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      send_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      send_q  <= send_d;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte (
    .clk   (clk),
    .rst   (rst),
    .start (byte_start),
    .din   (byte_din),
    .tx    (byte_tx),
    .busy  (byte_busy),
    .done  (byte_done)
  );

  assign bus.tx   = byte_tx;
  assign bus.busy = (state_q == SEND_CHAR) ||
                    (state_q == NEXT);
  assign bus.done = (state_q == FINISH);

endmodule

// File: tb/tb_arith_result_uart_tx.sv
// Directed and random message checks for arith_result_uart_tx,
// decoding the tx line against expected ASCII characters.
module tb_arith_result_uart_tx;

  localparam int DIV = 16;
  localparam int FRM = 10 * DIV;
  localparam int MSG = 4 * FRM;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arith_result_uart_tx_if bus ();

  arith_result_uart_tx #(
    .CLK_FREQUENCY (16),
    .BAUD_RATE     (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs = 0;
  int checks = 0;
  logic tx_s [MSG];
  logic busy_s [MSG];
  logic done_s [MSG];
  string hexd = "0123456789ABCDEF";

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(
    input logic [7:0] r, input logic o, input int k);
    logic [7:0] cv = "V";
    logic [7:0] cd = "-";
    logic [7:0] c;
    case (k)
      0: c = hexd[r[7:4]];
      1: c = hexd[r[3:0]];
      2: c = o ? cv : cd;
      default: c = 8'h0D;
    endcase
    return c;
  endfunction

  // mode 1: hold send high, extra edge in char1, result changed mid-message
  task automatic run_msg(input string tag,
                         input logic [7:0] r,
                         input logic o,
                         input int mode);
    logic [7:0] got;
    logic stable;
    int base, nbusy, ndone;
    bus.result = r;
    bus.overflow = o;
    bus.send = 1'b1;
    tick();
    if (mode != 1) bus.send = 1'b0;
    chk({tag, "_start"}, {30'd0, bus.tx, bus.busy}, 32'd1);
    for (int n = 0; n < MSG; n++) begin
      tx_s[n] = bus.tx;
      busy_s[n] = bus.busy;
      done_s[n] = bus.done;
      if (mode == 1) begin
        if (n == 100) bus.result = 8'h11;
        if (n == 200) bus.send = 1'b0;
        if (n == 210) bus.send = 1'b1;
      end
      tick();
    end
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_busy_drop"}, {31'd0, bus.busy}, 32'd0);
    nbusy = 0;
    ndone = 0;
    for (int n = 0; n < MSG; n++) begin
      if (busy_s[n] !== 1'b1) nbusy++;
      if (done_s[n] !== 1'b0) ndone++;
    end
    chk({tag, "_busy_gaps"}, nbusy, 0);
    chk({tag, "_early_done"}, ndone, 0);
    for (int k = 0; k < 4; k++) begin
      base = k * FRM;
      stable = 1'b1;
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < DIV; c++)
          if (tx_s[base + b*DIV + c] !== tx_s[base + b*DIV])
            stable = 1'b0;
      if (tx_s[base] !== 1'b0) stable = 1'b0;
      if (tx_s[base + 9*DIV] !== 1'b1) stable = 1'b0;
      for (int b = 0; b < 8; b++)
        got[b] = tx_s[base + (b+1)*DIV + DIV/2];
      chk($sformatf("%s_frame%0d", tag, k),
          {31'd0, stable}, 32'd1);
      chk($sformatf("%s_char%0d", tag, k),
          {24'd0, got}, {24'd0, exp_char(r, o, k)});
    end
  endtask

  initial begin
    int bad;
    logic [7:0] rr;
    logic ro;

    rst = 1'b1;
    bus.send = 1'b0;
    bus.result = 8'h00;
    bus.overflow = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.send = i[0];
      tick();
      chk("rst_hold", {29'd0, bus.tx, bus.busy, bus.done},
          32'b100);
    end
    bus.send = 1'b0;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    chk("rst_release_quiet", bad, 0);

    run_msg("t2", 8'h3C, 1'b0, 0);
    tick();
    tick();
    run_msg("t3a", 8'h80, 1'b1, 0);
    tick();
    run_msg("t3b", 8'hFF, 1'b0, 0);
    tick();
    run_msg("t3c", 8'h09, 1'b1, 0);
    tick();

    run_msg("t4", 8'h5E, 1'b1, 1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    chk("t4_no_retrigger", bad, 0);
    bus.send = 1'b0;
    tick();
    run_msg("t4b", 8'h11, 1'b0, 0);
    tick();

    bus.result = 8'h6B;
    bus.overflow = 1'b1;
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
    for (int i = 0; i < 350; i++) tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_mid", {29'd0, bus.tx, bus.busy, bus.done},
        32'b100);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0) bad++;
    end
    chk("t5_discarded", bad, 0);
    run_msg("t5", 8'hA5, 1'b0, 0);

    tick();
    chk("t6_gap", {30'd0, bus.tx, bus.busy}, 32'b10);
    run_msg("t6", 8'h4D, 1'b1, 0);
    tick();

    for (int i = 0; i < 3; i++) begin
      rr = 8'($urandom);
      ro = 1'($urandom);
      run_msg($sformatf("rnd%0d", i), rr, ro, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/arith_result_uart_tx.md
Name: arith_result_uart_tx

Overview:
- Downstream consumer of the 8-bit add/subtract stage.
- On a send request it latches the 8-bit result and the overflow flag, then transmits them over a UART 8N1 line as four ASCII characters:
  - two uppercase hex digits,
  - a flag character,
  - carriage return.
- Drives the board's UART TX pin.
- Gives the switch-driven calculator a serial readout alongside the LEDs.

Parameters:
- CLK_FREQUENCY, 100_000_000, system clock in Hz.
- BAUD_RATE, 19_200, line rate in bits per second.
- BAUD_DIV is derived as CLK_FREQUENCY/BAUD_RATE (integer divide), with 5208 at the defaults. It is a localparam, not overridable.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- send  input  1  transmit request; synchronous level, rising edge detected internally.
- result  input  8  sum/difference from the arithmetic stage.
- overflow  input  1  signed overflow flag from the arithmetic stage.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high while a 4-character message is in progress.
- done  output  1  one-cycle pulse when the message completes.

Behaviour:
- Reset values: tx=1, busy=0, done=0. Character index=0, bit counter=0, baud counter=0, send edge-detect register=0, capture registers=0.
- Reset mid-message:
  - Next cycle: tx=1, busy=0.
  - No done pulse.
  - Remaining characters are discarded.
- Start condition:
  - Occurs when send=1, the previous-cycle send=0, and the block is IDLE.
  - On that edge, result and overflow are captured into internal registers.
  - busy=1 and tx=0 (start bit) from the next cycle.
- Ignored send activity:
  - Send edges while busy are ignored.
  - Holding send high does not retrigger.
  - Changes on result/overflow after capture have no effect.
- Message, in this order:
  - char0 = hex(result[7:4])
  - char1 = hex(result[3:0])
  - char2 = 0x56 ('V') if overflow else 0x2D ('-')
  - char3 = 0x0D (CR)
- Hex encoding: nibble 0-9 maps to 0x30+n; nibble 10-15 maps to 0x41+(n-10).
- Frame per character: start bit 0, then data bits LSB first, then stop bit 1. Each of the 10 bit periods is exactly BAUD_DIV cycles.
- Characters are back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
- Top-level states:
  - IDLE -> SEND_CHAR, on start condition.
  - SEND_CHAR -> NEXT, when the byte transmitter signals done.
  - NEXT -> SEND_CHAR, if index<3; index increments.
  - NEXT -> FINISH, if index==3.
  - FINISH -> IDLE.
  - FINISH asserts done for exactly one cycle and drops busy in that same cycle.
- Bookkeeping states must not introduce tx gaps. Byte loads are pipelined so each stop-bit period remains exactly BAUD_DIV cycles.
- Total latency: from the first cycle tx=0 to the done pulse is 40*BAUD_DIV cycles.
- A new send edge is accepted the cycle after done.

Decomposition:
- Package arith_uart_pkg holds:
  - state enum {IDLE, SEND_CHAR, NEXT, FINISH}
  - ASCII constants CHAR_V=8'h56, CHAR_DASH=8'h2D, CHAR_CR=8'h0D, ASCII_ZERO=8'h30, ASCII_A=8'h41
  - NUM_CHARS=4
  - function nibble_to_ascii
- Sub-module uart_tx_byte:
  - Ports: clk, rst, start, din[7:0], tx, busy, done.
  - Owns the baud counter and bit counter, with internal states IDLE/START/DATA/STOP.
  - Top level owns capture, character sequencing and the done pulse.

Test Plan:
All cases run with CLK_FREQUENCY=16, BAUD_RATE=1, so BAUD_DIV=16.
1. Reset held 5 cycles with send toggling -> tx=1, busy=0, done=0 throughout, and no start bit after release.
2. result=8'h3C, overflow=0, one-cycle send:
   - tx decodes 0x33, 0x43, 0x2D, 0x0D.
   - Each bit is 16 cycles; no gaps between frames.
   - done pulses once, 640 cycles after the first start bit.
3. result=8'h80, overflow=1 -> bytes 0x38, 0x30, 0x56, 0x0D. Also result=8'hFF -> 0x46, 0x46 and result=8'h09 -> 0x30, 0x39 for the hex boundaries.
4. Send held high the whole message, plus an extra pulse during char1, and result changed to 8'h11 mid-message:
   - Exactly one message, carrying the original captured value.
   - No retrigger until send falls and rises again after done.
5. rst asserted during char2's data bits:
   - tx=1 and busy=0 on the next cycle, no done pulse.
   - A following send with result=8'hA5, overflow=0 transmits 0x41, 0x35, 0x2D, 0x0D cleanly.
6. Send edge on the cycle immediately after done -> second message starts: tx=0 the following cycle and busy re-asserts.
